sram_controller: RTL and testbench

- Bridges the ARM memory stage (32-bit word loads and stores) to the off-chip 16-bit SRAM.
- Each word is split into two half-word SRAM accesses, low half first.
- Deasserts `ready` while an access is in flight so the hazard/freeze logic stalls the pipeline.
- Owns every SRAM control pin; sole driver of the bidirectional `sram_dq` bus.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_controller_sram_access_timer.sv | 31 +++
 rtl/sram_controller.sv | 170 +++++++++++++++++
 tb/tb_sram_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the 32-bit CPU to 16-bit SRAM bridge.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int CPU_DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // True when a CPU byte address falls below the window or past the 512 KiB SRAM.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return (addr < base) || (off[31:19] != 13'd0);
    endfunction

endpackage

// File: rtl/sram_controller_sram_access_timer.sv
// Per-half access timer: counts the clocks a half-word stays on the SRAM pins.
module sram_access_timer #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Hold-time counter; cleared between halves and while the bridge is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign term = (cnt_r == CNT_W'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit CPU loads/stores into two 16-bit SRAM accesses, low half first.
// Define SRAM_CTRL_RANGE_CHECK_EN to add the addr_err port and out-of-window rejection.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [CPU_DATA_W-1:0]  write_data,
    output logic [CPU_DATA_W-1:0]  read_data,
    output logic                   ready,
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    output logic                   addr_err,
`endif
    output logic [SRAM_ADDR_W-1:0] sram_address,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n
);

    state_t                 state_r;
    logic [16:0]            word_addr_r;
    logic [15:0]            wdata_hi_r;
    logic                   is_wr_r;
    logic [15:0]            rdata_lo_r;
    logic [CPU_DATA_W-1:0]  read_data_r;
    logic [SRAM_ADDR_W-1:0] sram_address_r;
    logic                   sram_we_n_r;
    logic                   dq_oe_r;
    logic [SRAM_DATA_W-1:0] dq_out_r;

    logic [31:0] offset_s;
    logic        req_s;
    logic        range_err_s;
    logic        term_s;
    logic        tmr_clr_s;
    logic        tmr_inc_s;
    logic        unused_s;

    assign offset_s = address - BASE_ADDR;
    assign req_s    = wr_en | rd_en;
    assign unused_s = ^{offset_s[31:19], offset_s[1:0]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    assign range_err_s = addr_out_of_range(address, BASE_ADDR);
`else
    assign range_err_s = 1'b0;
`endif

    // Timer runs only while a half-word is on the pins and restarts at each half.
    always_comb begin
        tmr_inc_s = 1'b0;
        tmr_clr_s = 1'b1;
        if ((state_r == LO) || (state_r == HI)) begin
            tmr_inc_s = 1'b1;
            tmr_clr_s = term_s;
        end else begin
            tmr_inc_s = 1'b0;
            tmr_clr_s = 1'b1;
        end
    end

    sram_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr_s),
        .inc  (tmr_inc_s),
        .term (term_s)
    );

    // Access FSM; pin values are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            word_addr_r    <= 17'd0;
            wdata_hi_r     <= 16'd0;
            is_wr_r        <= 1'b0;
            rdata_lo_r     <= 16'd0;
            read_data_r    <= 32'd0;
            sram_address_r <= 18'd0;
            sram_we_n_r    <= 1'b1;
            dq_oe_r        <= 1'b0;
            dq_out_r       <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        word_addr_r <= offset_s[18:2];
                        wdata_hi_r  <= write_data[31:16];
                        is_wr_r     <= wr_en;
                        if (range_err_s) begin
                            state_r <= DONE;
                            if (!wr_en) begin
                                read_data_r <= 32'd0;
                            end
                        end else begin
                            state_r        <= LO;
                            sram_address_r <= {offset_s[18:2], 1'b0};
                            sram_we_n_r    <= ~wr_en;
                            dq_oe_r        <= wr_en;
                            dq_out_r       <= write_data[15:0];
                        end
                    end
                end
                LO: begin
                    if (term_s) begin
                        state_r        <= HI;
                        sram_address_r <= {word_addr_r, 1'b1};
                        dq_out_r       <= wdata_hi_r;
                        if (!is_wr_r) begin
                            rdata_lo_r <= sram_dq;
                        end
                    end
                end
                HI: begin
                    if (term_s) begin
                        state_r     <= DONE;
                        sram_we_n_r <= 1'b1;
                        dq_oe_r     <= 1'b0;
                        if (!is_wr_r) begin
                            read_data_r <= {sram_dq, rdata_lo_r};
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    sram_we_n_r <= 1'b1;
                    dq_oe_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic addr_err_r;

    // Flag is raised exactly for the DONE clock of a rejected request.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= (state_r == IDLE) && req_s && range_err_s;
        end
    end

    assign addr_err = addr_err_r;
`endif

    assign ready        = (state_r == DONE) | ((state_r == IDLE) & ~wr_en & ~rd_en);
    assign read_data    = read_data_r;
    assign sram_address = sram_address_r;
    assign sram_we_n    = sram_we_n_r;
    assign sram_dq      = dq_oe_r ? dq_out_r : {SRAM_DATA_W{1'bz}};
    assign sram_ub_n    = 1'b0;
    assign sram_lb_n    = 1'b0;
    assign sram_ce_n    = 1'b0;
    assign sram_oe_n    = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table, read-data scoreboard and a behavioural SRAM.
module tb_sram_controller;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_address;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic        addr_err;
`endif

    sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(AC)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .ready        (ready),
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        .addr_err     (addr_err),
`endif
        .sram_address (sram_address),
        .sram_dq      (sram_dq),
        .sram_we_n    (sram_we_n),
        .sram_ub_n    (sram_ub_n),
        .sram_lb_n    (sram_lb_n),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus whenever not being written; a write lands only
    // after the address has been held with we_n low for AC consecutive clocks.
    logic [15:0] mem [0:262143];
    int          hold_cnt = 0;
    logic [17:0] hold_addr = 18'd0;
    int          hold_next;
    int          cyc = 0;

    assign sram_dq   = sram_we_n ? mem[sram_address] : 16'hzzzz;
    assign hold_next = (hold_cnt != 0 && sram_address == hold_addr) ? hold_cnt + 1 : 1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sram_we_n) begin
            hold_cnt  <= hold_next;
            hold_addr <= sram_address;
            if (hold_next == AC) mem[sram_address] <= sram_dq;
        end else begin
            hold_cnt <= 0;
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] sb_q [$];
    logic [31:0] last_rd = 32'd0;
    int          prev_done = -1;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cycles;
        int   we_lo;
        int   exp_lat;
        logic [31:0] exp_rd;
        exp_lat = v.exp_err ? 1 : 2 * AC + 1;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, ready}, 32'd1);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        if (v.rd && !v.wr) last_rd = v.exp_rdata;
        sb_q.push_back(last_rd);
        #1;
        check("req_stall", {31'd0, ready}, 32'd0);
        cycles = 0;
        we_lo  = 0;
        do begin
            @(posedge clk); #1;
            wr_en = 1'b0; rd_en = 1'b0;
            cycles++;
            if (!sram_we_n) we_lo++;
        end while (!ready && cycles < 50);
        check("latency", cycles, exp_lat);
        check("we_n_low_clocks", we_lo, (v.wr && !v.exp_err) ? 2 * AC : 0);
        exp_rd = sb_q.pop_front();
        check("read_data", read_data, exp_rd);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        check("addr_err", {31'd0, addr_err}, {31'd0, v.exp_err});
`endif
        if (prev_done >= 0) check("back_to_back", cyc - prev_done, exp_lat + 1);
        prev_done = cyc;
    endtask

    initial begin
        vec_t tail;
        mem[7]          = 16'h7777;
        mem[18'h3FF00]  = 16'h1357;
        mem[18'h3FF01]  = 16'h2468;

        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'h12345678, 32'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'd0, 32'h12345678, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'd1032, 32'd0, 32'hA5A55A5A, 1'b0};
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        vecs[6] = '{1'b0, 1'b1, 32'd512, 32'd0, 32'd0, 1'b1};
`else
        vecs[6] = '{1'b0, 1'b1, 32'd512, 32'd0, 32'h24681357, 1'b0};
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_read_data", read_data, 32'd0);
        check("rst_sram_addr", {14'd0, sram_address}, 32'd0);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
`endif

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
        check("mem2", {16'd0, mem[2]}, 32'h00005678);
        check("mem3", {16'd0, mem[3]}, 32'h00001234);
        check("mem4", {16'd0, mem[4]}, 32'h00005A5A);
        check("mem5", {16'd0, mem[5]}, 32'h0000A5A5);

        // Reset in the first HI clock of a store: low half lands, high half must not.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        check("abort_read_data", read_data, 32'd0);
        check("mem6", {16'd0, mem[6]}, 32'h0000F00D);
        check("mem7", {16'd0, mem[7]}, 32'h00007777);

        last_rd   = 32'd0;
        prev_done = -1;
        tail = '{1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0};
        run_vec(tail);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
